pcie2fifo: RTL

PCIE2FIFO -- requirements
Module: pcie2fifo

---
 rtl/pcie2fifo.sv | 77 +++++++
 1 files changed

// File: rtl/pcie2fifo.sv
// PCIe RX AXI-stream to FIFO writer: admits whole TLPs when the FIFO has room
// for a maximum-length packet and discards the others, counting both outcomes.
module pcie2fifo #(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH/8,
  parameter int TUSER_WIDTH  = 22,
  parameter int DIN_WIDTH    = 2+KEEP_WIDTH+C_DATA_WIDTH+TUSER_WIDTH
) (
  input  logic                    pcie_clk,
  input  logic                    pcie_rst_n,
  input  logic                    pcie_tvalid,
  output logic                    pcie_tready,
  input  logic                    pcie_tlast,
  input  logic [KEEP_WIDTH-1:0]   pcie_tkeep,
  input  logic [C_DATA_WIDTH-1:0] pcie_tdata,
  input  logic [TUSER_WIDTH-1:0]  pcie_tuser,
  input  logic                    rx_enable,
  output logic                    wr_en,
  output logic [DIN_WIDTH-1:0]    din,
  input  logic                    full,
  input  logic                    prog_full,
  output logic [7:0]              tlp_pktcount,
  output logic [15:0]             drop_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  logic [1:0] state, state_next;
  logic       beat_accepted;
  logic       write_ok;

  // Dropped beats are sunk regardless of FIFO occupancy.
  assign pcie_tready   = (state == DROP) ? 1'b1 : !full;
  assign beat_accepted = pcie_tvalid && pcie_tready;

  // Admission is decided only at SOP; once inside a TLP the decision sticks.
  always_comb begin
    write_ok = 1'b0;
    case (state)
      IDLE:    write_ok = rx_enable && !prog_full;
      WRITE:   write_ok = 1'b1;
      default: write_ok = 1'b0;
    endcase
  end

  assign wr_en = pcie_rst_n && beat_accepted && write_ok;
  assign din   = wr_en ? {1'b1, pcie_tlast, pcie_tkeep, pcie_tdata, pcie_tuser}
                       : '0;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (beat_accepted && !pcie_tlast) state_next = write_ok ? WRITE : DROP;
      WRITE: if (beat_accepted && pcie_tlast)  state_next = IDLE;
      DROP:  if (beat_accepted && pcie_tlast)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The packet count moves only on the final written beat, so readers see whole TLPs.
  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      state        <= IDLE;
      tlp_pktcount <= 8'h00;
      drop_count   <= 16'h0000;
    end else begin
      state <= state_next;
      if (wr_en && pcie_tlast)
        tlp_pktcount <= tlp_pktcount + 8'd1;
      if (state == IDLE && beat_accepted && !write_ok && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

endmodule
